// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, the legal digit
// codes (bit0=a .. bit6=g, lit=1) and the forward BCD-to-segment table.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Forward table used by the display decoder; blank for non-BCD input.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] code;
    code = 7'h00;
    case (digit)
      4'd0: code = SEG_CODE_0;
      4'd1: code = SEG_CODE_1;
      4'd2: code = SEG_CODE_2;
      4'd3: code = SEG_CODE_3;
      4'd4: code = SEG_CODE_4;
      4'd5: code = SEG_CODE_5;
      4'd6: code = SEG_CODE_6;
      4'd7: code = SEG_CODE_7;
      4'd8: code = SEG_CODE_8;
      4'd9: code = SEG_CODE_9;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational inverse of the seven-segment decoder: maps a segment pattern
// back to its BCD digit, flagging anything that is not a legal 0-9 code.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       err
);

  // Exact match against the ten legal codes; everything else is invalid.
  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b1;
    case (pattern)
      SEG_CODE_0: begin bcd = 4'd0; err = 1'b0; end
      SEG_CODE_1: begin bcd = 4'd1; err = 1'b0; end
      SEG_CODE_2: begin bcd = 4'd2; err = 1'b0; end
      SEG_CODE_3: begin bcd = 4'd3; err = 1'b0; end
      SEG_CODE_4: begin bcd = 4'd4; err = 1'b0; end
      SEG_CODE_5: begin bcd = 4'd5; err = 1'b0; end
      SEG_CODE_6: begin bcd = 4'd6; err = 1'b0; end
      SEG_CODE_7: begin bcd = 4'd7; err = 1'b0; end
      SEG_CODE_8: begin bcd = 4'd8; err = 1'b0; end
      SEG_CODE_9: begin bcd = 4'd9; err = 1'b0; end
      default: begin bcd = BCD_INVALID; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed common-cathode display bus: synchronizes segments and
// strobes, captures each digit once its pattern has settled, and hands a
// complete scan to the consumer as one frame.
//
// Frame handshake: frame_valid stays high and frame_bcd/frame_err stay
// stable until a cycle with frame_valid & frame_ready; that cycle is the
// transfer. A frame completing on the transfer cycle is loaded directly, so
// back-to-back frames need no idle cycle. A frame completing while the
// previous one is still waiting is dropped and flagged in overflow.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]              seg_meta;
  logic [6:0]              s_seg;
  logic [NUM_DIGITS-1:0]   en_meta;
  logic [NUM_DIGITS-1:0]   s_en;
  logic [CW-1:0]           stable_cnt;
  logic [CW-1:0]           cnt_next;
  logic                    sample_same;
  logic                    sample_hot;
  logic                    capture;
  logic [3:0]              dec_bcd;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [NUM_DIGITS-1:0]   seen_mask;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    frame_done;
  logic                    frame_take;

  // Two-flop synchronizer for the pad bus; s_seg/s_en are the settled copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta <= '0;
      s_seg    <= '0;
      en_meta  <= '0;
      s_en     <= '0;
    end else begin
      seg_meta <= seg_in;
      s_seg    <= seg_meta;
      en_meta  <= dig_en;
      s_en     <= en_meta;
    end
  end

  // The sample about to enter s_seg/s_en is compared with the current one, so
  // stable_cnt equals (identical synchronized samples - 1) and the capture
  // edge is the one that completes STABLE_CYCLES identical samples.
  assign sample_same = ({seg_meta, en_meta} == {s_seg, s_en});
  assign sample_hot  = (en_meta != '0) &&
                       ((en_meta & (en_meta - NUM_DIGITS'(1))) == '0);
  assign capture     = sample_hot && sample_same &&
                       (stable_cnt == CW'(STABLE_CYCLES - 2));

  seg7_pattern_to_bcd u_decode (
    .pattern (seg_meta),
    .bcd     (dec_bcd),
    .err     (dec_err)
  );

  // Next stability count: restart on any change or non-one-hot strobe, saturate.
  always_comb begin
    cnt_next = stable_cnt;
    if (!sample_hot || !sample_same) begin
      cnt_next = '0;
    end else if (stable_cnt != CW'(STABLE_CYCLES)) begin
      cnt_next = stable_cnt + CW'(1);
    end
  end

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= cnt_next;
    end
  end

  // Digit slots: the strobed digit is overwritten on capture (latest wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_bcd <= '0;
      slot_err <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && en_meta[k]) begin
          slot_bcd[4*k +: 4] <= dec_bcd;
          slot_err[k]        <= dec_err;
        end
      end
    end
  end

  assign frame_done = &seen_mask;
  assign frame_take = frame_done && (!frame_valid || frame_ready);

  // Seen mask restarts when a scan completes, keeping any same-edge capture.
  always_comb begin
    seen_next = frame_done ? '0 : seen_mask;
    if (capture) begin
      seen_next = seen_next | en_meta;
    end
  end

  // Seen-mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_mask <= '0;
    end else begin
      seen_mask <= seen_next;
    end
  end

  // Frame output register and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_bcd   <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
    end else if (frame_take) begin
      frame_bcd   <= slot_bcd;
      frame_err   <= slot_err;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (frame_done && frame_valid && !frame_ready) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: table-driven scans, directed multi-cycle
// corner cases and a random dwell sequence checked against a dwell-level
// reference model with a frame scoreboard.
module tb_seg7_scan_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [N-1:0]  dig_en;
  logic [4*N-1:0] frame_bcd;
  logic [N-1:0]  frame_err;
  logic          frame_valid;
  logic          frame_ready;
  logic          overflow;
  logic          ovf_clr;

  int errors = 0;
  int checks = 0;
  int frames_seen = 0;

  logic [4*N+N-1:0] exp_q[$];   // {err, bcd} of every frame the consumer should receive

  seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: legal code table and dwell-level capture rules
  logic [6:0] legal [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0]  m_bcd [N];
  logic        m_err [N];
  logic [N-1:0] m_mask;
  logic [10:0] m_last;
  int          m_run;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (p == legal[i]) return {1'b0, 4'(i)};
    end
    return {1'b1, 4'hF};
  endfunction

  // A pad value held for n edges extends the run if unchanged; a one-hot run
  // crossing S samples captures that digit exactly once.
  task automatic model_dwell(input logic [N-1:0] en, input logic [6:0] seg, input int n);
    int prev;
    logic [4:0] d;
    logic [4*N+N-1:0] fr;
    if ({en, seg} == m_last) begin
      prev = m_run;
      m_run = m_run + n;
    end else begin
      prev = 0;
      m_run = n;
    end
    m_last = {en, seg};
    if ($countones(en) == 1 && prev < S && m_run >= S) begin
      d = ref_decode(seg);
      for (int k = 0; k < N; k++) begin
        if (en[k]) begin
          m_bcd[k] = d[3:0];
          m_err[k] = d[4];
        end
      end
      m_mask = m_mask | en;
      if (m_mask == '1) begin
        for (int k = 0; k < N; k++) begin
          fr[4*k +: 4] = m_bcd[k];
          fr[4*N + k]  = m_err[k];
        end
        exp_q.push_back(fr);
        m_mask = '0;
      end
    end
  endtask

  // Driver: hold a pad value for n rising edges (called just after an edge)
  task automatic dwell(input logic [N-1:0] en, input logic [6:0] seg, input int n);
    model_dwell(en, seg, n);
    dig_en = en;
    seg_in = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    dwell('0, 7'h00, n);
  endtask

  task automatic scan(input logic [7*N-1:0] pats, input int n);
    for (int d = 0; d < N; d++) begin
      dwell(N'(1) << d, pats[7*d +: 7], n);
    end
  endtask

  // Hold a settling digit and check frame_valid rises exactly at edge +2+S
  task automatic dwell_latency(input string name, input logic [N-1:0] en, input logic [6:0] seg);
    model_dwell(en, seg, S + 2);
    dig_en = en;
    seg_in = seg;
    for (int i = 1; i <= S + 2; i++) begin
      @(posedge clk);
      #1;
      if (i == S + 1) check({name, "_early"}, 32'(frame_valid), 32'd0);
      if (i == S + 2) check({name, "_rise"}, 32'(frame_valid), 32'd1);
    end
  endtask

  // Scoreboard: every transfer must match the next expected frame
  always @(negedge clk) begin : monitor
    logic [4*N+N-1:0] e;
    if (rst_n && frame_valid && frame_ready) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none at %0t",
                 {frame_err, frame_bcd}, $time);
      end else begin
        e = exp_q.pop_front();
        check("frame", 32'({frame_err, frame_bcd}), 32'(e));
      end
    end
  end

  typedef struct {
    logic [7*N-1:0] pats;
    logic [4*N-1:0] bcd;
    logic [N-1:0]   err;
  } vec_t;

  vec_t tbl [5];

  initial begin : stim
    int saved;
    logic [N-1:0] ren;
    logic [6:0]   rseg;

    tbl[0] = '{pats: {7'h4F, 7'h5B, 7'h06, 7'h3F}, bcd: 16'h3210, err: 4'b0000};
    tbl[1] = '{pats: {7'h07, 7'h7D, 7'h6D, 7'h66}, bcd: 16'h7654, err: 4'b0000};
    tbl[2] = '{pats: {7'h06, 7'h3F, 7'h6F, 7'h7F}, bcd: 16'h1098, err: 4'b0000};
    tbl[3] = '{pats: {7'h7C, 7'h5B, 7'h00, 7'h3F}, bcd: 16'hF2F0, err: 4'b1010};
    tbl[4] = '{pats: {7'h7F, 7'h00, 7'h01, 7'h77}, bcd: 16'h8FFF, err: 4'b0111};

    m_mask = '0;
    m_last = '0;
    m_run  = 0;

    // Reset
    rst_n = 1'b0;
    seg_in = '0;
    dig_en = '0;
    frame_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd", 32'(frame_bcd), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Table-driven full scans
    for (int v = 0; v < 5; v++) begin
      saved = frames_seen;
      scan(tbl[v].pats, 8);
      idle(2);
      check("tbl_count", 32'(frames_seen - saved), 32'd1);
      check("tbl_bcd", 32'(frame_bcd), 32'(tbl[v].bcd));
      check("tbl_err", 32'(frame_err), 32'(tbl[v].err));
      check("tbl_valid_low", 32'(frame_valid), 32'd0);
    end

    // Too-short dwell on digit 2 captures nothing; a full dwell completes
    saved = frames_seen;
    dwell(4'b0001, 7'h3F, 8);
    dwell(4'b0010, 7'h06, 8);
    dwell(4'b1000, 7'h4F, 8);
    dwell(4'b0100, 7'h5B, S - 1);
    idle(6);
    check("short_no_frame", 32'(frames_seen - saved), 32'd0);
    dwell_latency("short_then_full", 4'b0100, 7'h5B);
    idle(2);
    check("short_bcd", 32'(frame_bcd), 32'h3210);

    // Consumer stalled over two scans: hold first, drop second
    frame_ready = 1'b0;
    scan({7'h4F, 7'h5B, 7'h06, 7'h3F}, 8);
    idle(3);
    check("stall_valid", 32'(frame_valid), 32'd1);
    check("stall_ovf0", 32'(overflow), 32'd0);
    scan({7'h07, 7'h7D, 7'h6D, 7'h66}, 8);
    idle(3);
    check("stall_hold_bcd", 32'(frame_bcd), 32'h3210);
    check("stall_ovf1", 32'(overflow), 32'd1);
    check("stall_queue", 32'(exp_q.size()), 32'd2);
    void'(exp_q.pop_back());
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    frame_ready = 1'b1;
    idle(2);
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    check("stall_valid_low", 32'(frame_valid), 32'd0);

    // Two strobes at once never capture; a glitch restarts the count
    saved = frames_seen;
    dwell(4'b0010, 7'h06, 8);
    dwell(4'b0100, 7'h5B, 8);
    dwell(4'b1000, 7'h4F, 8);
    dwell(4'b0011, 7'h3F, 10);
    idle(4);
    check("twohot_no_frame", 32'(frames_seen - saved), 32'd0);
    dwell(4'b0001, 7'h3F, S - 1);
    dwell(4'b0000, 7'h3F, 1);
    dwell_latency("glitch_restart", 4'b0001, 7'h3F);
    idle(2);

    // Reset mid-frame discards the partial scan
    dwell(4'b0001, 7'h7D, 8);
    dwell(4'b0010, 7'h07, 8);
    dwell(4'b0100, 7'h7F, 8);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(frame_bcd), 32'd0);
    check("midrst_valid", 32'(frame_valid), 32'd0);
    m_mask = '0;
    m_last = '0;
    m_run  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saved = frames_seen;
    dwell(4'b1000, 7'h6F, 8);
    idle(4);
    check("midrst_no_frame", 32'(frames_seen - saved), 32'd0);
    dwell(4'b0001, 7'h7D, 8);
    dwell(4'b0010, 7'h07, 8);
    dwell(4'b0100, 7'h7F, 8);
    idle(3);
    check("midrst_fresh_bcd", 32'(frame_bcd), 32'h9876);
    check("midrst_fresh_count", 32'(frames_seen - saved), 32'd1);

    // Random dwells against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) ren = N'(1) << $urandom_range(0, N - 1);
      else ren = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 9) < 8) rseg = legal[$urandom_range(0, 9)];
      else rseg = 7'($urandom_range(0, 127));
      dwell(ren, rseg, $urandom_range(1, 7));
    end
    idle(8);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_ovf", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart to the team's BCD-to-seven-segment decoder: samples a multiplexed common-cathode display bus (segment lines plus one-hot digit strobes), waits for each digit's pattern to settle, maps each pattern back to BCD, and assembles one complete scan of all digits into a frame. The frame is handed to the consumer over a valid/ready handshake. The block sits between the display pads and on-chip logic, for display loop-back checking and for reading external seven-segment drivers.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (strobe width), 1..8
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture, >=2
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- seg_in  in  7  segment lines, bit0=a .. bit6=g, active-high (lit=1)
- dig_en  in  NUM_DIGITS  digit strobes, active-high, one-hot when valid
- frame_bcd  out  4*NUM_DIGITS  digit k in bits [4k+3:4k]
- frame_err  out  NUM_DIGITS  bit k set: digit k pattern not a legal 0-9 code
- frame_valid  out  1  frame outputs hold a frame
- frame_ready  in  1  consumer accepts the frame when frame_valid & frame_ready
- overflow  out  1  sticky: a completed frame was dropped
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- seg_in and dig_en pass through a 2-flop synchronizer; all further logic uses synchronized values (s_seg, s_en).
- Legal codes (g..a, hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; any other pattern, including 00, yields BCD 4'hF and err=1.
- Stability counter: cleared when s_en is not one-hot, or {s_seg,s_en} differs from the previous cycle; otherwise increments, saturating at STABLE_CYCLES.
- Capture: on the cycle the counter reaches STABLE_CYCLES-1 (i.e. STABLE_CYCLES identical one-hot samples), the decoded BCD/err is written to the digit slot selected by s_en and that digit's bit is set in seen_mask. Exactly one capture per dwell; a longer dwell does not recapture.
- A recapture of a digit before the frame completes overwrites its slot (latest value wins).
- Frame complete when seen_mask is all ones:
  - if frame_valid=0, or frame_valid & frame_ready this cycle: load frame_bcd/frame_err, frame_valid=1, clear seen_mask.
  - else: discard, set overflow, clear seen_mask; frame outputs unchanged.
- Handshake: frame_valid & frame_ready with no new frame completing -> frame_valid=0 next cycle. frame_bcd/frame_err stable while frame_valid=1 and not accepted.
- ovf_clr and a same-cycle new overflow: overflow stays 1 (set wins).

## Timing
- Reset values: frame_bcd=0, frame_err=0, frame_valid=0, overflow=0; synchronizer, counter, seen_mask, digit slots all 0.
- rst_n assertion mid-dwell or mid-frame discards all partial state immediately; the first frame after release requires every digit captured afresh.
- Latency: pad value stable from edge k -> digit slot written at edge k+1+STABLE_CYCLES; frame_valid rises on the same edge as the completing capture plus one (edge k+2+STABLE_CYCLES for the last digit).
- Back-to-back frames accepted with no bubble when frame_ready is held high.

## Structure
- Shared package seg7_pkg: segment bit indices (SEG_A..SEG_G), legal code constants SEG_CODE_0..SEG_CODE_9, BCD_INVALID=4'hF; the existing decoder's table is defined from the same constants.
- One sub-module: seg7_pattern_to_bcd (combinational, 7-bit pattern -> 4-bit BCD + err), reusable by other checkers.
- Top holds synchronizer, stability counter, digit slots, seen_mask, frame/handshake registers.

## Test plan
- Reset, then scan digits 0..3 with patterns 3F,06,5B,4F for 8 cycles each, frame_ready=1 -> one frame, frame_bcd=16'h3210, frame_err=0, frame_valid high one cycle.
- Dwell only 3 cycles (STABLE_CYCLES=4) on digit 2 -> no capture, no frame; extend dwell to 4 -> frame completes.
- Digit 1 driven 00, digit 3 driven 7C -> frame_bcd=16'hF2F0 pattern slots 1,3 = F, frame_err=4'b1010.
- frame_ready=0 across two full scans -> first frame held unchanged, second dropped, overflow=1; ovf_clr pulse -> overflow=0.
- Two strobes high (dig_en=4'b0011) for 10 cycles -> no capture; glitch of 1 cycle inside a dwell restarts count (capture delayed accordingly).
- rst_n pulsed after 3 of 4 digits captured -> outputs reset values; next frame needs all 4 digits.
